// File: rtl/alu_op_decoder_pkg.sv
// Shared types for the ALU op decoder stage.
// Field widths and the ALU operand-mode encoding.
package alu_op_decoder_pkg;

    typedef logic [2:0] Funct3_t;
    typedef logic [6:0] Funct7_t;

    typedef enum logic {
        REGISTER = 1'b0,
        OP_IMM   = 1'b1
    } ALUMode_t;

    typedef struct packed {
        Funct3_t     funct3;
        Funct7_t     funct7;
        ALUMode_t    mode;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_op_decoder_if.sv
// Instruction-in / decoded-op-out handshake bundle.
// master = decoder side, slave = fetch/issue environment side.
interface alu_op_decoder_if;
    import alu_op_decoder_pkg::*;

    logic        instrValid;
    logic        instrReady;
    logic [31:0] instruction;
    logic        opValid;
    logic        opReady;
    Funct3_t     funct3;
    Funct7_t     funct7;
    ALUMode_t    aluMode;
    logic [31:0] immediateI;
    logic [4:0]  rs1Index;
    logic [4:0]  rs2Index;
    logic [4:0]  rdIndex;
    logic        illegal;

    modport master (
        input  instrValid, instruction, opReady,
        output instrReady, opValid, funct3, funct7, aluMode,
        output immediateI, rs1Index, rs2Index, rdIndex, illegal
    );

    modport slave (
        output instrValid, instruction, opReady,
        input  instrReady, opValid, funct3, funct7, aluMode,
        input  immediateI, rs1Index, rs2Index, rdIndex, illegal
    );

endinterface

// File: rtl/alu_op_decoder.sv
// RV32I OP / OP-IMM decode stage with a two-entry skid buffer.
// Optional macro ALU_DECODE_SHIFT_CHECK_EN checks shift-immediate upper bits.
module alu_op_decoder
    import alu_op_decoder_pkg::*;
(
    input logic             clock,
    input logic             reset_n,
    alu_op_decoder_if.master bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    state_t state, state_nx;
    logic   ready_q;
    dec_t   dec, out_q, skid_q;
    logic   in_fire, out_fire;
    logic   load_out, load_skid, sel_skid;

    logic [6:0] opcode;
    Funct3_t    f3;
    Funct7_t    up;
    logic       is_op, is_imm, is_shift, shift_bad;

    assign opcode   = bus.instruction[6:0];
    assign f3       = bus.instruction[14:12];
    assign up       = bus.instruction[31:25];
    assign is_op    = (opcode == OPC_OP);
    assign is_imm   = (opcode == OPC_IMM);
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    // Shift-immediate upper-bit legality (only enforced when enabled)
    always_comb begin
        shift_bad = 1'b0;
`ifdef ALU_DECODE_SHIFT_CHECK_EN
        shift_bad = is_shift &&
                    !((up == 7'b0) || (up == F7_ALT && f3 == 3'b101));
`endif
    end

    // Decode the incoming word before it is registered
    always_comb begin
        dec         = '0;
        dec.mode    = OP_IMM;
        dec.illegal = 1'b1;
        unique case (1'b1)
            is_op: begin
                dec.mode    = REGISTER;
                dec.funct3  = f3;
                dec.funct7  = up;
                dec.imm     = {{20{bus.instruction[31]}},
                               bus.instruction[31:20]};
                dec.rs1     = bus.instruction[19:15];
                dec.rs2     = bus.instruction[24:20];
                dec.rd      = bus.instruction[11:7];
                dec.illegal = !((up == 7'b0) ||
                                (up == F7_ALT &&
                                 (f3 == 3'b000 || f3 == 3'b101)));
            end
            is_imm: begin
                dec.mode    = OP_IMM;
                dec.funct3  = f3;
                dec.funct7  = is_shift ? up : 7'b0;
                dec.imm     = {{20{bus.instruction[31]}},
                               bus.instruction[31:20]};
                dec.rs1     = bus.instruction[19:15];
                dec.rs2     = 5'd0;
                dec.rd      = bus.instruction[11:7];
                dec.illegal = shift_bad;
            end
            default: begin
                dec         = '0;
                dec.mode    = OP_IMM;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign in_fire  = bus.instrValid && ready_q;
    assign out_fire = bus.opReady && (state != EMPTY);

    // Occupancy next-state and register load controls
    always_comb begin
        state_nx  = state;
        load_out  = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
        unique case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nx = ONE;
                    load_out = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_nx  = TWO;
                    load_skid = 1'b1;
                end else if (in_fire && out_fire) begin
                    load_out = 1'b1;
                end else if (out_fire) begin
                    state_nx = EMPTY;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nx = ONE;
                    load_out = 1'b1;
                    sel_skid = 1'b1;
                end
            end
            default: state_nx = EMPTY;
        endcase
    end

    // State, registered ready, output and skid registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx != TWO);
            if (load_out)
                out_q <= sel_skid ? skid_q : dec;
            if (load_skid)
                skid_q <= dec;
        end
    end

    assign bus.instrReady = ready_q;
    assign bus.opValid    = (state != EMPTY);
    assign bus.funct3     = out_q.funct3;
    assign bus.funct7     = out_q.funct7;
    assign bus.aluMode    = out_q.mode;
    assign bus.immediateI = out_q.imm;
    assign bus.rs1Index   = out_q.rs1;
    assign bus.rs2Index   = out_q.rs2;
    assign bus.rdIndex    = out_q.rd;
    assign bus.illegal    = out_q.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Bench for alu_op_decoder: vector table through a scoreboard,
// plus stall, reset-in-TWO and idle-ready sequences.
module tb_alu_op_decoder;
    import alu_op_decoder_pkg::*;

    typedef struct packed {
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        mode;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } fields_t;

    typedef struct {
        logic [31:0] w;
        fields_t     exp;
    } vec_t;

`ifdef ALU_DECODE_SHIFT_CHECK_EN
    localparam logic SHIFT_CHK = 1'b1;
`else
    localparam logic SHIFT_CHK = 1'b0;
`endif

    localparam int NV = 13;

    logic clock = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;
    int   cur_idx = 0;
    int   q[$];
    vec_t vec[NV];

    alu_op_decoder_if bus ();

    alu_op_decoder dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    function automatic fields_t act();
        fields_t a;
        a.f3   = bus.funct3;
        a.f7   = bus.funct7;
        a.mode = (bus.aluMode == OP_IMM);
        a.imm  = bus.immediateI;
        a.rs1  = bus.rs1Index;
        a.rs2  = bus.rs2Index;
        a.rd   = bus.rdIndex;
        a.ill  = bus.illegal;
        return a;
    endfunction

    function automatic vec_t mk(
        logic [31:0] w, logic [2:0] f3, logic [6:0] f7,
        logic m, logic [31:0] imm, logic [4:0] rs1,
        logic [4:0] rs2, logic [4:0] rd, logic ill);
        vec_t v;
        v.w = w;
        v.exp = '{f3, f7, m, imm, rs1, rs2, rd, ill};
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Scoreboard: push on accepted input, pop/compare on consumed output
    always @(negedge clock) begin
        if (reset_n) begin
            if (bus.opValid && bus.opReady) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out got=%h", act());
                end else begin
                    int i;
                    i = q.pop_front();
                    if (act() !== vec[i].exp) begin
                        bad++;
                        $display("FAIL out_vec%0d got=%h want=%h",
                                 i, act(), vec[i].exp);
                    end
                end
            end
            if (bus.instrValid && bus.instrReady)
                q.push_back(cur_idx);
        end
    end

    task automatic send(int i);
        bus.instrValid  = 1'b1;
        bus.instruction = vec[i].w;
        cur_idx = i;
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (bus.instrReady) begin
                @(posedge clock);
                #1;
                bus.instrValid = 1'b0;
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL send_timeout vec%0d", i);
        bus.instrValid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 50; n++) begin
            @(negedge clock);
            if (q.size() == 0) begin
                @(negedge clock);
                chk("drain_opvalid", 64'(bus.opValid), 64'd0);
                return;
            end
        end
        total++;
        bad++;
        $display("FAIL drain_timeout got=%0d want=0", q.size());
    endtask

    task automatic drive(int i);
        @(posedge clock);
        #1;
        bus.instrValid  = 1'b1;
        bus.instruction = vec[i].w;
        cur_idx = i;
    endtask

    initial begin
        vec[0]  = mk(32'h002081B3, 3'd0, 7'h00, 1'b0,
                     32'h00000002, 5'd1, 5'd2, 5'd3, 1'b0);
        vec[1]  = mk(32'h402081B3, 3'd0, 7'h20, 1'b0,
                     32'h00000402, 5'd1, 5'd2, 5'd3, 1'b0);
        vec[2]  = mk(32'h40209133, 3'd1, 7'h20, 1'b0,
                     32'h00000402, 5'd1, 5'd2, 5'd2, 1'b1);
        vec[3]  = mk(32'hFFF00293, 3'd0, 7'h00, 1'b1,
                     32'hFFFFFFFF, 5'd0, 5'd0, 5'd5, 1'b0);
        vec[4]  = mk(32'h4030D093, 3'd5, 7'h20, 1'b1,
                     32'h00000403, 5'd1, 5'd0, 5'd1, 1'b0);
        vec[5]  = mk(32'h02109093, 3'd1, 7'h01, 1'b1,
                     32'h00000021, 5'd1, 5'd0, 5'd1, SHIFT_CHK);
        vec[6]  = mk(32'h00000073, 3'd0, 7'h00, 1'b1,
                     32'h00000000, 5'd0, 5'd0, 5'd0, 1'b1);
        vec[7]  = mk(32'h8000C093, 3'd4, 7'h00, 1'b1,
                     32'hFFFFF800, 5'd1, 5'd0, 5'd1, 1'b0);
        vec[8]  = mk(32'h0030D093, 3'd5, 7'h00, 1'b1,
                     32'h00000003, 5'd1, 5'd0, 5'd1, 1'b0);
        vec[9]  = mk(32'h40309093, 3'd1, 7'h20, 1'b1,
                     32'h00000403, 5'd1, 5'd0, 5'd1, SHIFT_CHK);
        vec[10] = mk(32'h022081B3, 3'd0, 7'h01, 1'b0,
                     32'h00000022, 5'd1, 5'd2, 5'd3, 1'b1);
        vec[11] = mk(32'h4020D1B3, 3'd5, 7'h20, 1'b0,
                     32'h00000402, 5'd1, 5'd2, 5'd3, 1'b0);
        vec[12] = mk(32'h0000A083, 3'd0, 7'h00, 1'b1,
                     32'h00000000, 5'd0, 5'd0, 5'd0, 1'b1);

        reset_n         = 1'b0;
        bus.instrValid  = 1'b0;
        bus.instruction = 32'h0;
        bus.opReady     = 1'b0;

        #2;
        chk("rst_opvalid", 64'(bus.opValid), 64'd0);
        chk("rst_ready", 64'(bus.instrReady), 64'd0);
        chk("rst_fields", 64'(act()), 64'd0);

        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("ready_before_edge", 64'(bus.instrReady), 64'd0);
        @(negedge clock);
        chk("ready_after_edge", 64'(bus.instrReady), 64'd1);

        bus.opReady = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("idle_opready", 64'(bus.opValid), 64'd0);
        end

        for (int i = 0; i < NV; i++)
            send(i);
        drain();

        bus.opReady = 1'b0;
        drive(0);
        drive(3);
        drive(4);
        @(negedge clock);
        chk("stall_ready", 64'(bus.instrReady), 64'd0);
        chk("stall_hold0", 64'(act()), 64'(vec[0].exp));
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("stall_hold1", 64'(act()), 64'(vec[0].exp));
        chk("stall_qsize", 64'(q.size()), 64'd2);
        @(posedge clock);
        #1 bus.opReady = 1'b1;
        @(negedge clock);
        chk("burst_v1", 64'(bus.opValid), 64'd1);
        @(negedge clock);
        chk("burst_v2", 64'(bus.opValid), 64'd1);
        @(posedge clock);
        #1 bus.instrValid = 1'b0;
        @(negedge clock);
        chk("burst_v3", 64'(bus.opValid), 64'd1);
        @(negedge clock);
        chk("burst_end", 64'(bus.opValid), 64'd0);
        chk("burst_qsize", 64'(q.size()), 64'd0);

        bus.opReady = 1'b0;
        drive(1);
        drive(2);
        @(posedge clock);
        #1 bus.instrValid = 1'b0;
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("midrst_opvalid", 64'(bus.opValid), 64'd0);
        chk("midrst_ready", 64'(bus.instrReady), 64'd0);
        chk("midrst_fields", 64'(act()), 64'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        @(negedge clock);
        chk("post_rst_empty", 64'(bus.opValid), 64'd0);
        bus.opReady = 1'b1;
        send(11);
        drain();
        send(7);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_op_decoder.md
# alu_op_decoder

Pipelined decode stage that is the producing end of the ALU control/operand interface. It accepts 32-bit RV32I instruction words over a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011). It presents `funct3`, `funct7`, `aluMode`, sign-extended `immediateI` and register indices to the ALU issue path. A two-entry skid buffer gives full throughput without a combinational ready path.

## Interface
- No parameters.
- `clock` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `instrValid` input 1: `instruction` is valid this cycle.
- `instrReady` output 1: decoder accepts a word this cycle.
- `instruction` input 32: RV32I instruction word.
- `opValid` output 1: decoded operation presented.
- `opReady` input 1: downstream consumes the presented operation.
- `funct3` output Funct3_t: instruction[14:12].
- `funct7` output Funct7_t: see Operation.
- `aluMode` output ALUMode_t: REGISTER or OP_IMM.
- `immediateI` output 32: sign-extended instruction[31:20].
- `rs1Index`, `rs2Index`, `rdIndex` output 5 each: instruction[19:15], [24:20], [11:7].
- `illegal` output 1: presented word is not a legal OP/OP-IMM encoding.

## Operation
Decode rules, evaluated on the accepted word:
- **Opcode 0110011:** `aluMode`=REGISTER; `funct7`=instruction[31:25].
  - Illegal unless funct7 is 0000000, or funct7 is 0100000 with funct3 000 or 101.
- **Opcode 0010011:** `aluMode`=OP_IMM.
  - funct3 001/101: `funct7`=instruction[31:25].
  - Other funct3: `funct7` forced to 0000000.
  - `rs2Index` forced to 0.
- **Any other opcode:** `illegal`=1, `aluMode`=OP_IMM, `funct3`=0, `funct7`=0, `immediateI`=0, all indices 0.
  - The word is still carried through the pipeline.
- Illegal words are presented with `opValid`=1; the consumer traps.

Buffer state machine (occupancy):
- **EMPTY**
  - Transfer in → ONE.
- **ONE** (output register full)
  - Transfer in with no transfer out → TWO; word goes to the skid register.
  - Transfer in with transfer out → ONE; output register reloads.
  - Transfer out only → EMPTY.
- **TWO** (output and skid full)
  - Transfer out → ONE; skid moves to the output register.
  - No transfer in is possible in this state.

Handshake and register rules:
- A transfer occurs when valid and ready are both high on a rising edge.
- `instrReady` = (state ≠ TWO), driven from a register only.
- `opValid` = (state ≠ EMPTY).
- Outputs hold stable while `opValid`=1 and `opReady`=0.
- Decode logic sits before the output/skid registers, so both registers hold decoded fields.

## Timing
- Latency: a word accepted at edge N is presented from edge N (visible in cycle N+1) when the buffer was EMPTY, or when it was ONE with a simultaneous transfer out.
- Throughput: one operation per cycle with `opReady` held high.
- Reset (asynchronous on `reset_n` low, released synchronously by the user):
  - State EMPTY, `opValid`=0, `instrReady`=0 while in reset, 1 from the first edge after release.
  - All data outputs 0; `aluMode`=REGISTER; `illegal`=0.
- Reset mid-operation discards both buffered entries with no partial output.
- Simultaneous in/out in ONE keeps order: the old entry leaves, the new entry takes its place.
- `opReady` high while EMPTY has no effect.

## Configuration
- `ALU_DECODE_SHIFT_CHECK_EN`
  - Defined: an OP-IMM shift (funct3 001 or 101) is illegal unless instruction[31:25] is 0000000, or 0100000 with funct3 101 only.
  - Undefined: shift-immediate upper bits are not checked. `illegal` for OP-IMM depends only on opcode, and `funct7` still passes instruction[31:25].

## Test plan
- After reset, drive 0x002081B3 (add x3,x1,x2) with `opReady`=1 → next cycle: `opValid`=1, REGISTER, funct3=000, funct7=0000000, rs1=1, rs2=2, rd=3, `illegal`=0.
- 0x402081B3 (sub) → funct7=0100000, REGISTER, `illegal`=0; 0x40209133 (funct7 0100000 with funct3 001) → `illegal`=1.
- 0xFFF00293 (addi x5,x0,-1) → OP_IMM, immediateI=0xFFFFFFFF, funct7=0, rs2=0, rd=5. 0x4030D093 (srai x1,x1,3) → funct7=0100000, immediateI=0x00000403.
- 0x02109093 (slli, bad upper bits) → `illegal`=1 with the macro defined, 0 without. 0x00000073 (ecall) → `illegal`=1 and all fields 0.
- Stall: stream 3 words with `opReady`=0 → first two accepted, `instrReady`=0 after the second, outputs hold word 1. Raise `opReady` → words 1, 2, 3 emerge in order on consecutive cycles.
- Pull `reset_n` low while in TWO → `opValid`=0 immediately; after release, the first new word emerges with no stale data.
